// File: rtl/seq_detect_param.sv
// seq_detect_param
// ----------------
// Serial pattern detector. Bits arrive on din and are consumed only on
// clock edges where din_vld=1. The last PAT_W-1 consumed bits are held in
// a history register (oldest at the MSB). A match is declared when the
// history is fully populated and {history, din} equals PATTERN. The first
// bit received is the pattern's MSB.
//
// Handshake: din_vld is a valid-only qualifier with no ready. The block
// accepts every qualified bit on the rising edge where din_vld=1. Bits
// with din_vld=0 are ignored and leave all state untouched.
//
// Parameters
//   PAT_W    pattern length in bits (2..16)
//   PATTERN  target sequence, MSB first
//   OVERLAP  1 = overlapping matches, 0 = each match needs PAT_W fresh bits
//   CNT_W    width of the saturating match counter
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   din        serial data bit
//   din_vld    din qualifier
//   clr        synchronous clear of history, fill and match count
//   dout       registered one-cycle match pulse
//   match_cnt  saturating count of matches since reset or clr
//   armed      registered: history full, the next valid bit can complete a match

module seq_detect_param #(
  parameter int              PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b10101,
  parameter bit              OVERLAP = 1'b1,
  parameter int              CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  input  logic             clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  // The fill counter saturates at PAT_W-1. $clog2(PAT_W) bits are enough
  // to hold PAT_W-1 for every legal PAT_W, including 16 (4 bits, value 15).
  localparam int               FILL_W    = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [PAT_W-2:0]  history;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  window;
  logic              hit;
  logic [FILL_W-1:0] fill_next;

  always_comb begin
    window    = {history, din};
    hit       = din_vld && (fill == FILL_FULL) && (window == PATTERN);
    fill_next = fill;
    // Non-overlapping mode restarts the fill count on a match. The stale
    // history bits are harmless because they are all shifted out again
    // before fill can reach FILL_FULL.
    if (hit && !OVERLAP) begin
      fill_next = '0;
    end else if (fill != FILL_FULL) begin
      fill_next = fill + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      history   <= '0;
      fill      <= '0;
      match_cnt <= '0;
      dout      <= 1'b0;
      armed     <= 1'b0;
    end else if (clr) begin
      // clr wins over a bit presented on the same edge: that bit is dropped.
      history   <= '0;
      fill      <= '0;
      match_cnt <= '0;
      dout      <= 1'b0;
      armed     <= 1'b0;
    end else begin
      dout <= hit;
      if (din_vld) begin
        history <= window[PAT_W-2:0];
        fill    <= fill_next;
        // armed tracks the registered fill value, so decode the next value.
        armed   <= (fill_next == FILL_FULL);
        if (hit && (match_cnt != CNT_MAX)) begin
          match_cnt <= match_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param. Three instances share one stimulus stream:
//   u_a : PAT_W=5, PATTERN=10101, OVERLAP=1, CNT_W=8
//   u_b : PAT_W=3, PATTERN=101,   OVERLAP=1, CNT_W=2
//   u_c : PAT_W=3, PATTERN=101,   OVERLAP=0, CNT_W=8
// The reference model keeps each instance's consumed bits in a queue and
// looks for the pattern in the most recent bits of that queue.
module tb_seq_detect_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic din = 1'b0;
  logic din_vld = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic       dout_a, dout_b, dout_c;
  logic       armed_a, armed_b, armed_c;
  logic [7:0] cnt_a, cnt_c;
  logic [1:0] cnt_b;

  seq_detect_param #(.PAT_W(5), .PATTERN(5'b10101), .OVERLAP(1'b1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr(clr),
    .dout(dout_a), .match_cnt(cnt_a), .armed(armed_a));

  seq_detect_param #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b1), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr(clr),
    .dout(dout_b), .match_cnt(cnt_b), .armed(armed_b));

  seq_detect_param #(.PAT_W(3), .PATTERN(3'b101), .OVERLAP(1'b0), .CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .clr(clr),
    .dout(dout_c), .match_cnt(cnt_c), .armed(armed_c));

  int dout_v[3];
  int armed_v[3];
  int cnt_v[3];
  assign dout_v[0]  = int'(dout_a);
  assign dout_v[1]  = int'(dout_b);
  assign dout_v[2]  = int'(dout_c);
  assign armed_v[0] = int'(armed_a);
  assign armed_v[1] = int'(armed_b);
  assign armed_v[2] = int'(armed_c);
  assign cnt_v[0]   = int'(cnt_a);
  assign cnt_v[1]   = int'(cnt_b);
  assign cnt_v[2]   = int'(cnt_c);

  // ---------------- reference model ----------------
  int pw[3]   = '{5, 3, 3};
  int pat[3]  = '{21, 5, 5};
  int ov[3]   = '{1, 1, 0};
  int cmax[3] = '{255, 3, 255};

  bit hq[3][$];
  int m_dout[3]  = '{0, 0, 0};
  int m_armed[3] = '{0, 0, 0};
  int m_cnt[3]   = '{0, 0, 0};
  int pulses[3]  = '{0, 0, 0};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      hq[k].delete();
      m_dout[k]  = 0;
      m_armed[k] = 0;
      m_cnt[k]   = 0;
    end
  endtask

  // Called once per rising clock edge, with the inputs that edge sampled.
  task automatic model_step();
    if (rst || clr) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      bit hit;
      int w;
      hit       = 1'b0;
      m_dout[k] = 0;
      if (din_vld) begin
        hq[k].push_back(din);
        if (hq[k].size() >= pw[k]) begin
          w = 0;
          for (int i = 0; i < pw[k]; i++)
            w = (w << 1) | int'(hq[k][hq[k].size() - pw[k] + i]);
          hit = (w == pat[k]);
        end
        if (hit) begin
          m_dout[k] = 1;
          if (m_cnt[k] < cmax[k]) m_cnt[k]++;
          if (ov[k] == 0) hq[k].delete();
        end
        while (hq[k].size() > pw[k] - 1) void'(hq[k].pop_front());
      end
      m_armed[k] = (hq[k].size() == pw[k] - 1) ? 1 : 0;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      check($sformatf("dout[%0d]", k), dout_v[k], m_dout[k]);
      check($sformatf("match_cnt[%0d]", k), cnt_v[k], m_cnt[k]);
      check($sformatf("armed[%0d]", k), armed_v[k], m_armed[k]);
      if (dout_v[k] == 1) pulses[k]++;
    end
  end

  // ---------------- driver ----------------
  // Inputs change on the falling edge; the model follows the rising edge;
  // directed checks sample #1 after the rising edge.
  task automatic feed(input bit b, input bit v, input bit c);
    @(negedge clk);
    din     = b;
    din_vld = v;
    clr     = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_pulses();
    for (int k = 0; k < 3; k++) pulses[k] = 0;
  endtask

  bit s1_bits[9] = '{0, 0, 1, 0, 1, 0, 1, 0, 0};
  bit s3_bits[5] = '{1, 0, 1, 0, 1};
  int s3_gaps[4] = '{1, 2, 3, 1};
  int s4_cnt[5]  = '{1, 2, 3, 3, 3};

  initial begin
    // Reset
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout_a", int'(dout_a), 0);
    check("reset_cnt_a", int'(cnt_a), 0);
    check("reset_armed_a", int'(armed_a), 0);
    #1 rst = 1'b0;

    // S1: 0,0,1,0,1,0,1,0,0 back to back
    clear_pulses();
    for (int i = 0; i < 9; i++) begin
      feed(s1_bits[i], 1'b1, 1'b0);
      if (i == 6) check("s1_pulse_after_bit7_a", int'(dout_a), 1);
      if (i == 5) check("s1_no_pulse_bit6_a", int'(dout_a), 0);
      if (i == 4) check("s1_pulse_after_bit5_c", int'(dout_c), 1);
    end
    feed(1'b0, 1'b0, 1'b0);
    check("s1_pulses_a", pulses[0], 1);
    check("s1_cnt_a", int'(cnt_a), 1);
    check("s1_pulses_b_overlap", pulses[1], 2);
    check("s1_cnt_b_overlap", int'(cnt_b), 2);
    check("s1_pulses_c_nonoverlap", pulses[2], 1);
    check("s1_cnt_c_nonoverlap", int'(cnt_c), 1);

    // S3: 10101 with idle gaps carrying junk on din
    feed(1'b0, 1'b0, 1'b1);
    check("s3_clr_cnt_a", int'(cnt_a), 0);
    clear_pulses();
    for (int i = 0; i < 5; i++) begin
      feed(s3_bits[i], 1'b1, 1'b0);
      if (i < 4) for (int g = 0; g < s3_gaps[i]; g++) feed(1'b1, 1'b0, 1'b0);
    end
    check("s3_pulse_after_last_a", int'(dout_a), 1);
    check("s3_pulses_a", pulses[0], 0);
    feed(1'b0, 1'b0, 1'b0);
    check("s3_pulse_single_cycle_a", int'(dout_a), 0);
    check("s3_total_pulses_a", pulses[0], 1);

    // S4: saturation of the 2-bit counter on u_b
    feed(1'b0, 1'b0, 1'b1);
    clear_pulses();
    for (int i = 0; i < 11; i++) begin
      feed(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0);
      if ((i % 2) == 0 && i >= 2) begin
        check($sformatf("s4_cnt_b_match%0d", i / 2), int'(cnt_b), s4_cnt[i / 2 - 1]);
        check($sformatf("s4_dout_b_match%0d", i / 2), int'(dout_b), 1);
      end
    end
    feed(1'b0, 1'b0, 1'b0);
    check("s4_pulses_b", pulses[1], 5);

    // S5: reset in the middle of a partial pattern
    feed(1'b0, 1'b0, 1'b1);
    clear_pulses();
    feed(1'b1, 1'b1, 1'b0);
    feed(1'b0, 1'b1, 1'b0);
    feed(1'b1, 1'b1, 1'b0);
    feed(1'b0, 1'b1, 1'b0);
    check("s5_armed_before_rst_a", int'(armed_a), 1);
    @(posedge clk);
    model_step();
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("s5_armed_in_rst_a", int'(armed_a), 0);
    check("s5_cnt_in_rst_b", int'(cnt_b), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    feed(1'b1, 1'b1, 1'b0);
    check("s5_no_pulse_a", int'(dout_a), 0);
    check("s5_armed_after_a", int'(armed_a), 0);
    check("s5_cnt_after_a", int'(cnt_a), 0);
    feed(1'b0, 1'b0, 1'b0);
    check("s5_pulses_a", pulses[0], 0);

    // S6: clr on the edge of the completing bit
    feed(1'b0, 1'b0, 1'b1);
    clear_pulses();
    feed(1'b1, 1'b1, 1'b0);
    feed(1'b0, 1'b1, 1'b0);
    feed(1'b1, 1'b1, 1'b0);
    feed(1'b0, 1'b1, 1'b0);
    feed(1'b1, 1'b1, 1'b1);
    check("s6_dout_a", int'(dout_a), 0);
    check("s6_cnt_a", int'(cnt_a), 0);
    check("s6_armed_a", int'(armed_a), 0);
    feed(1'b1, 1'b1, 1'b0);
    check("s6_no_late_pulse_a", int'(dout_a), 0);
    feed(1'b0, 1'b0, 1'b0);
    check("s6_pulses_a", pulses[0], 0);

    // Short random tail, checked only by the model compare
    for (int i = 0; i < 200; i++)
      feed(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 40) == 0));
    feed(1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
